alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single-cycle integer ALU between two requesters, requester 0 (execute stage) and requester 1 (branch/compare unit), through valid/ready handshakes. Each cycle at most one request is granted and computed. The result is registered together with its owner ID and returned on that requester's response channel. The block sits between the control/decode logic and the ALU datapath and is the only path to the ALU in the core.

## Interface
- Parameters:
- `W`, 32, operand and result width.
- Ports (`i` ∈ {0,1}):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  requester i has an operation.
- `req_ready_i`  out  1  request i accepted this cycle.
- `req_ctl_i`  in  4  ALU control code.
- `req_a_i`, `req_b_i`  in  W  operands, unsigned.
- `rsp_valid_i`  out  1  result available for requester i.
- `rsp_ready_i`  in  1  requester i consumes the result.
- `rsp_result_i`  out  W  result. Valid while `rsp_valid_i` is high.
- `rsp_zero_i`  out  1  high when the result equals 0.

## Operation
- ALU codes:
  - 0 = AND
  - 1 = OR
  - 2 = ADD, modulo 2^W
  - 6 = SUB, modulo 2^W
  - 7 = unsigned A<B, result 1 or 0
  - 12 = NOR
  - any other code gives result 0, with zero = 1
- Zero flag: zero = (result == 0) for every code, not only SUB.
- FSM has two states:
  - EMPTY: result register holds no data.
  - FULL: result register holds data plus an owner ID.
- `free` = EMPTY, or (FULL and `rsp_ready` of the owner is high).
- Grant: a requester may be granted only while `free` is true.
- Handshake rules:
  - `req_ready_i` is high only for the granted requester, and only when `free` is true. It is computed combinationally.
  - A request transfers when `req_valid_i && req_ready_i`.
  - A requester must hold its `ctl`, `a` and `b` stable while valid is high and ready is low.
- Transitions:
  - EMPTY → FULL on an accept.
  - FULL → EMPTY when the owner consumes and there is no new accept.
  - FULL → FULL when the owner consumes and a new accept occurs in the same cycle (back-to-back).
- Responses:
  - `rsp_valid_i` = FULL && owner == i.
  - The non-owner sees `rsp_valid` = 0, and its result and zero outputs are 0.
- Both requesters valid in the same cycle: resolved by the arbitration policy (see Configuration). The loser's `req_ready` stays low. The loser must keep its request valid (no drop).
- Owner not ready: the result is held unchanged, and both `req_ready` outputs stay low.
- `rsp_ready` of the non-owner is ignored.
- Reset, asynchronous and also mid-operation:
  - state → EMPTY, owner = 0, result register = 0, zero = 0.
  - RR pointer set so that requester 0 is preferred next.
  - All `rsp_valid` = 0.
  - Any in-flight result is discarded.

## Timing
- Latency: request accepted at edge N, `rsp_valid` high in the cycle after edge N.
- Throughput: one operation per cycle while owners consume immediately.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. `rsp_*` outputs are registered only (no combinational path from the inputs).
- The ALU compute path is combinational from the granted request's operands to the result register D input, within one cycle.

## Configuration
- Macro `ALU_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration.
  - On a conflict, the requester that did not win the last accept is granted.
  - The pointer updates only on an accept.
- Undefined: fixed priority, requester 0 always wins. Requester 1 may starve.

## Structure
- Shared package `alu_pkg`:
  - enum `alu_ctl_e` with AND=4'd0, OR=4'd1, ADD=4'd2, SUB=4'd6, SLTU=4'd7, NOR=4'd12.
  - FSM state enum {EMPTY, FULL}.
  - `ALU_W` = 32.
- One sub-module, `alu_datapath`: combinational.
  - Inputs: ctl, a, b.
  - Outputs: result, zero.
  - Decodes the codes above, with default → 0.
- The arbiter, FSM and result register live in `alu_arbiter`.

## Test plan
- Reset, then req0 ADD a=7, b=5, with rsp_ready0 = 1 → one cycle later `rsp_valid0` = 1, result 12, zero 0; `rsp_valid1` = 0.
- req1 SUB a=9, b=9 → result 0, zero 1. Then SLTU a=3, b=0xFFFFFFFF → result 1. Then code 4'd3 → result 0, zero 1.
- Both requesters valid every cycle, both rsp_ready = 1:
  - with RR: grants alternate 0,1,0,1…
  - without RR: requester 0 every cycle, `req_ready1` never high.
- req0 AND 0xF0 & 0x3C accepted with rsp_ready0 = 0 for 3 cycles → result 0x30 held. `req_ready0` and `req_ready1` stay low. On the rsp_ready0 pulse, a waiting req1 is accepted in the same cycle.
- Back-to-back: req0 issues OR and then NOR on consecutive cycles with rsp_ready0 = 1 → two results on consecutive cycles, no bubble.
- Assert rst_n low while FULL → all `rsp_valid` drop immediately and the result register reads 0. After release, the first conflict is granted to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Holds the ALU control codes, the result-register FSM states and the default width.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [3:0] {
    AluAnd  = 4'd0,
    AluOr   = 4'd1,
    AluAdd  = 4'd2,
    AluSub  = 4'd6,
    AluSltu = 4'd7,
    AluNor  = 4'd12
  } alu_ctl_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_arbiter.
// Index 0 is the execute stage, index 1 is the branch/compare unit.
interface alu_arbiter_if #(
  parameter int unsigned W = 32
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_ctl;
  logic [1:0][W-1:0] req_a;
  logic [1:0][W-1:0] req_b;

  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [1:0][W-1:0] rsp_result;
  logic [1:0]        rsp_zero;

  // Requester side.
  modport master (
    output req_valid, req_ctl, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_ctl, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );

endinterface

// File: rtl/alu_datapath.sv
// Combinational integer ALU. Unknown codes give a zero result (and so zero = 1).
module alu_datapath
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [3:0]   ctl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zero
);

  // Decode the control code and derive the zero flag from the result.
  always_comb begin
    result = '0;
    case (ctl)
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluSltu: result = {{(W-1){1'b0}}, (a < b)};
      AluNor:  result = ~(a | b);
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared single-cycle ALU.
// One request is granted per cycle while the result register is free; the result is
// registered with its owner ID and returned on the owner's response channel.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0
// has fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  arb_state_e  state_q;
  logic        owner_q;
  logic [W-1:0] result_q;
  logic        zero_q;

  logic        free;
  logic        prefer1;
  logic [1:0]  gnt;
  logic        accept;
  logic        sel;
  logic [W-1:0] alu_result;
  logic        alu_zero;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Requester that won the most recent accept; reset to 1 so requester 0 goes first.
  logic last_q;

  // Pointer moves only on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= sel;
    end
  end

  assign prefer1 = ~last_q;
`else
  assign prefer1 = 1'b0;
`endif

  // Grant one valid requester while the result register can take a new result.
  always_comb begin
    free = (state_q == StEmpty) || bus.rsp_ready[owner_q];
    gnt  = 2'b00;
    if (free) begin
      if (bus.req_valid[0] && !(bus.req_valid[1] && prefer1)) begin
        gnt[0] = 1'b1;
      end else if (bus.req_valid[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  assign accept        = |gnt;
  assign sel           = gnt[1];
  assign bus.req_ready = gnt;

  alu_datapath #(
    .W (W)
  ) u_datapath (
    .ctl    (bus.req_ctl[sel]),
    .a      (bus.req_a[sel]),
    .b      (bus.req_b[sel]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Result-register FSM: capture on accept, drain when the owner consumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q  <= StFull;
            owner_q  <= sel;
            result_q <= alu_result;
            zero_q   <= alu_zero;
          end
        end
        StFull: begin
          // accept implies the owner consumed this cycle (free was true).
          if (accept) begin
            owner_q  <= sel;
            result_q <= alu_result;
            zero_q   <= alu_zero;
          end else if (bus.rsp_ready[owner_q]) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  // Responses come straight from registers; the non-owner sees all zeros.
  always_comb begin
    bus.rsp_valid[0]  = (state_q == StFull) && !owner_q;
    bus.rsp_valid[1]  = (state_q == StFull) && owner_q;
    bus.rsp_result[0] = bus.rsp_valid[0] ? result_q : '0;
    bus.rsp_result[1] = bus.rsp_valid[1] ? result_q : '0;
    bus.rsp_zero[0]   = bus.rsp_valid[0] & zero_q;
    bus.rsp_zero[1]   = bus.rsp_valid[1] & zero_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   evals;
  int   fails;

  alu_arbiter_if #(.W(32)) bus ();

  alu_arbiter #(
    .W (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int i, input logic [3:0] ctl, input logic [31:0] a,
                     input logic [31:0] b);
    bus.req_valid[i] = 1'b1;
    bus.req_ctl[i]   = ctl;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
  endtask

  initial begin
    logic [1:0] exp_gnt;
    evals = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req_valid  = '0;
    bus.req_ctl    = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = '0;

    // Reset state.
    step();
    step();
    chk("reset_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("reset_result0", bus.rsp_result[0], 32'd0);
    chk("reset_zero", {30'd0, bus.rsp_zero}, 32'd0);
    rst_n = 1'b1;
    #2;

    // req0 ADD 7+5.
    bus.rsp_ready = 2'b11;
    req(0, 4'd2, 32'd7, 32'd5);
    #1;
    chk("add_ready", {30'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid[0] = 1'b0;
    chk("add_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
    chk("add_result", bus.rsp_result[0], 32'd12);
    chk("add_zero", {31'd0, bus.rsp_zero[0]}, 32'd0);
    chk("add_result1", bus.rsp_result[1], 32'd0);

    // req1 SUB 9-9.
    req(1, 4'd6, 32'd9, 32'd9);
    #1;
    chk("sub_ready", {30'd0, bus.req_ready}, 32'd2);
    step();
    chk("sub_rsp_valid", {30'd0, bus.rsp_valid}, 32'd2);
    chk("sub_result", bus.rsp_result[1], 32'd0);
    chk("sub_zero", {31'd0, bus.rsp_zero[1]}, 32'd1);

    // req1 SLTU 3 < 0xFFFFFFFF.
    req(1, 4'd7, 32'd3, 32'hFFFF_FFFF);
    step();
    chk("sltu_result", bus.rsp_result[1], 32'd1);
    chk("sltu_zero", {31'd0, bus.rsp_zero[1]}, 32'd0);

    // Undefined code 3.
    req(1, 4'd3, 32'd5, 32'd6);
    step();
    chk("undef_result", bus.rsp_result[1], 32'd0);
    chk("undef_zero", {31'd0, bus.rsp_zero[1]}, 32'd1);
    bus.req_valid[1] = 1'b0;
    step();
    chk("drain_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);

    // Conflict: both valid every cycle, both consume immediately.
    req(0, 4'd2, 32'd1, 32'd1);
    req(1, 4'd2, 32'd2, 32'd2);
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b01;
`endif
      #1;
      chk("conflict_ready", {30'd0, bus.req_ready}, {30'd0, exp_gnt});
      step();
      chk("conflict_rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, exp_gnt});
      chk("conflict_result", exp_gnt[0] ? bus.rsp_result[0] : bus.rsp_result[1],
          exp_gnt[0] ? 32'd2 : 32'd4);
    end
    bus.req_valid = 2'b00;
    step();

    // Owner stalls: AND held, nothing else accepted, non-owner ready ignored.
    bus.rsp_ready = 2'b10;
    req(0, 4'd0, 32'hF0, 32'h3C);
    #1;
    chk("and_ready", {30'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid[0] = 1'b0;
    req(1, 4'd2, 32'd10, 32'd20);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_ready", {30'd0, bus.req_ready}, 32'd0);
      chk("hold_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
      chk("hold_result", bus.rsp_result[0], 32'h30);
      step();
    end
    bus.rsp_ready = 2'b11;
    #1;
    chk("pulse_ready", {30'd0, bus.req_ready}, 32'd2);
    step();
    chk("pulse_rsp_valid", {30'd0, bus.rsp_valid}, 32'd2);
    chk("pulse_result", bus.rsp_result[1], 32'd30);
    bus.req_valid[1] = 1'b0;
    step();
    chk("pulse_drain", {30'd0, bus.rsp_valid}, 32'd0);

    // Back-to-back OR then NOR from requester 0.
    req(0, 4'd1, 32'hF0, 32'h0F);
    #1;
    chk("or_ready", {30'd0, bus.req_ready}, 32'd1);
    step();
    chk("or_result", bus.rsp_result[0], 32'hFF);
    req(0, 4'd12, 32'hF0, 32'h0F);
    #1;
    chk("nor_ready", {30'd0, bus.req_ready}, 32'd1);
    step();
    chk("nor_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
    chk("nor_result", bus.rsp_result[0], 32'hFFFF_FF00);
    bus.req_valid[0] = 1'b0;
    step();

    // Reset while FULL.
    req(0, 4'd2, 32'd1, 32'd2);
    step();
    bus.req_valid[0] = 1'b0;
    bus.rsp_ready = 2'b00;
    chk("prerst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("midrst_result_reg", dut.result_q, 32'd0);
    #2;
    rst_n = 1'b1;
    bus.rsp_ready = 2'b11;
    req(0, 4'd2, 32'd1, 32'd1);
    req(1, 4'd2, 32'd2, 32'd2);
    #1;
    chk("postrst_ready", {30'd0, bus.req_ready}, 32'd1);
    step();
    chk("postrst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
    chk("postrst_result", bus.rsp_result[0], 32'd2);
    bus.req_valid = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
